// File: rtl/capture_readout.sv
// Streams the circular capture memory out oldest-first, selecting one channel lane,
// with a 2-entry output FIFO hiding the sync-read RAM latency behind valid/ready.
module capture_readout #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_CHANNELS = 1,
  localparam int CSW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              waddr,
  input  logic [ADDR_WIDTH:0]                length,
  input  logic [CSW-1:0]                     chan_sel,
  output logic                               mem_ren,
  output logic [ADDR_WIDTH-1:0]              mem_raddr,
  input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] mem_rdata,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [DATA_WIDTH-1:0]              o_data,
  output logic                               o_last,
  output logic                               busy,
  output logic                               done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     last_idx_q, last_idx_d;
  logic [CSW-1:0]          chan_q, chan_d;
  logic [ADDR_WIDTH:0]     issued_q, issued_d;
  logic [ADDR_WIDTH:0]     beat_q, beat_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   fifo_q [2];
  logic [DATA_WIDTH-1:0]   fifo_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   lane;
  logic                    push, pop;
  logic [1:0]              credit_used;

  assign o_valid   = (count_q != 2'd0);
  assign o_data    = fifo_q[rd_ptr_q];
  assign o_last    = o_valid && (beat_q == last_idx_q);
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_raddr = waddr_q + issued_q[ADDR_WIDTH-1:0];

  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (chan_q == CSW'(k)) lane = mem_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Credit counts the slot freed by this cycle's pop, so o_ready=1 streams without bubbles.
  assign push        = rvalid_q;
  assign pop         = o_valid && o_ready;
  assign credit_used = count_q - {1'b0, pop} + {1'b0, rvalid_q};
  assign mem_ren     = (state_q == READ) && (issued_q < len_q) && (credit_used < 2'd2);

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    len_d      = len_q;
    last_idx_d = last_idx_q;
    chan_d     = chan_q;
    issued_d   = issued_q;
    beat_d     = beat_q;
    rvalid_d   = mem_ren;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (start) begin
          waddr_d    = waddr;
          len_d      = length;
          last_idx_d = length - (ADDR_WIDTH+1)'(1);
          chan_d     = chan_sel;
          issued_d   = '0;
          beat_d     = '0;
          state_d    = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (mem_ren) begin
          issued_d = issued_q + (ADDR_WIDTH+1)'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && o_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      beat_d   = beat_q + (ADDR_WIDTH+1)'(1);
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = lane;
      wr_ptr_d         = ~wr_ptr_q;
    end

    busy_d = (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      len_q      <= '0;
      last_idx_q <= '0;
      chan_q     <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      rvalid_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      len_q      <= len_d;
      last_idx_q <= last_idx_d;
      chan_q     <= chan_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      rvalid_q   <= rvalid_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// Randomized bench for capture_readout: a sync-read RAM model feeds the DUT and every
// beat is compared with a queue built from the circular-buffer and lane-select rules.
module tb_capture_readout;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 5;
  localparam int CSW = 3;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [AW:0]       length = '0;
  logic [CSW-1:0]    chan_sel = '0;
  logic              mem_ren;
  logic [AW-1:0]     mem_raddr;
  logic [DW*NC-1:0]  mem_rdata = '0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [DW-1:0]     o_data;
  logic              o_last;
  logic              busy;
  logic              done;

  logic [DW*NC-1:0]  mem [DEPTH];
  logic [DW-1:0]     exp_data [$];
  int                n_checks = 0;
  int                n_pass = 0;

  capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .reset(reset), .start(start), .waddr(waddr), .length(length),
    .chan_sel(chan_sel), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_last(o_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One readout; abort_at>0 pulls reset after that many beats, mid_start pokes start while busy.
  task automatic run(input int wa, input int len, input int ch, input bit rnd,
                     input int abort_at, input bit mid_start);
    int cyc, beats, first_v, last_hs, done_cyc, done_cnt, bubbles;
    bit stalled;
    logic [DW-1:0] hold_d;
    logic [DW*NC-1:0] w;
    exp_data.delete();
    for (int j = 0; j < len; j++) begin
      w = mem[(wa + j) % DEPTH];
      exp_data.push_back((ch < NC) ? w[ch*DW +: DW] : '0);
    end
    @(posedge clk); #1;
    waddr = AW'(wa); length = (AW+1)'(len); chan_sel = CSW'(ch); start = 1'b1;
    o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; beats = 0; first_v = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
    bubbles = 0; stalled = 1'b0; hold_d = '0;
    while (cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) check("ren_latency", mem_ren, len != 0);
      if (o_valid && first_v < 0) first_v = cyc;
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, hold_d);
      end
      if (first_v >= 0 && !o_valid && beats < len && !rnd) bubbles++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (mid_start && cyc == 3) begin
        start = 1'b1; waddr = '0; length = (AW+1)'(1);
      end
      if (mid_start && cyc == 4) start = 1'b0;
      if (o_valid && o_ready) begin
        if (beats < len) begin
          check("data", o_data, exp_data[beats]);
          check("last", o_last, beats == len - 1);
        end else begin
          check("extra_beat", beats, len - 1);
        end
        beats++;
        if (beats == len) last_hs = cyc;
        stalled = 1'b0;
      end else begin
        stalled = o_valid;
        hold_d = o_data;
      end
      if (abort_at > 0 && beats == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", o_valid, 0);
        check("abort_busy", busy, 0);
        reset = 1'b1;
        return;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
      if (rnd) o_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("beats", beats, len);
    check("done_once", done_cnt, 1);
    if (len == 0) begin
      check("done_lat0", done_cyc, 0);
      check("no_valid", first_v, -1);
    end else begin
      check("valid_lat", first_v, 2);
      check("done_lat", done_cyc, last_hs + 1);
    end
    if (!rnd && len > 0) check("bubbles", bubbles, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (DW*NC)'(i);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", mem_ren, 0);
    reset = 1'b1;

    run(5, 16, 0, 1'b0, 0, 1'b0);
    run(5, 16, 0, 1'b1, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      mem[i] = {8'($urandom), 32'hDDCCBBAA + 32'(i)};
    run(int'($urandom_range(0, 15)), 16, 2, 1'b0, 0, 1'b0);
    run(int'($urandom_range(0, 15)), 16, 5, 1'b1, 0, 1'b0);
    run(int'($urandom_range(0, 15)), 9, 4, 1'b0, 0, 1'b0);
    run(3, 0, 0, 1'b0, 0, 1'b0);
    run(15, 1, 0, 1'b0, 0, 1'b0);
    for (int t = 0; t < 8; t++)
      run(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 1'b0);

    run(2, 16, 1, 1'b0, 7, 1'b1);
    run(5, 16, 0, 1'b0, 0, 1'b0);
    run(14, 16, 3, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
